fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO (write-clock domain) between NUM_REQ independent producers. It grants one requester at a time and forwards that requester's valid/data as the FIFO write enable and write data. It honours the FIFO's registered full flag so that no write is ever dropped, and it bounds each grant to a burst of beats so that no producer can starve the others.

## Interface
- NUM_REQ, 4: number of requesters, ≥2
- DATA_WIDTH, 8: FIFO write data width
- MAX_BURST, 8: maximum accepted beats per grant, ≥1; ignored when packet lock is compiled in
- IDW, $clog2(NUM_REQ): grant index width (derived)
- clk  in  1  write-domain clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ×DATA_WIDTH  per-requester data, packed, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  end-of-packet marker; used only with packet lock
- req_ready  out  NUM_REQ  per-requester accept
- wfull  in  1  FIFO full flag (registered in the FIFO write domain)
- wren  out  1  FIFO write enable
- wdata  out  DATA_WIDTH  FIFO write data
- grant_id  out  IDW  index of the currently granted requester
- busy  out  1  a grant is active

## Operation
- States ARB_IDLE and ARB_GRANT.
- ARB_IDLE: if any req_valid is high, pick the winner as the first set bit searching upward from rr_ptr with wrap. Register grant_id, clear beat_cnt, and go to ARB_GRANT. With no valid, stay in ARB_IDLE.
- ARB_GRANT, where g = grant_id:
  - req_ready[g] = !wfull; all other ready bits are 0.
  - wren = req_valid[g] && !wfull.
  - wdata = req_data[g].
- An accepted beat is a cycle with wren high. Each accepted beat increments beat_cnt, which has width $clog2(MAX_BURST+1).
- Release (macro off): go to ARB_IDLE when either of these holds:
  - an accepted beat brings beat_cnt to MAX_BURST;
  - req_valid[g] is low in a cycle.
- On release: rr_ptr <= (g+1) mod NUM_REQ, with explicit wrap when NUM_REQ is not a power of two.
- While wfull is high, the grant is held, beat_cnt is held, and there is no timeout.
- Requesters follow valid/ready: once valid is high, data is held until ready.
- Outside ARB_GRANT, wren = 0, req_ready = 0, and wdata = 0.
- Reset values:
  - state ARB_IDLE; grant_id 0; rr_ptr 0; beat_cnt 0; busy 0.
  - wren 0; req_ready 0; wdata 0.
- An asynchronous reset in mid-grant aborts immediately. The partial burst is not resumed.

## Timing
- The grant decision is registered: req_valid sampled in ARB_IDLE gives the first possible wren on the next cycle.
- wren, req_ready and wdata are combinational from the registered grant, req_valid and wfull. There is no added latency, which is mandatory because wfull reflects the FIFO state at the same edge.
- There is one ARB_IDLE bubble cycle between consecutive grants.
- Maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles while contended.
- busy = (state == ARB_GRANT); it is registered.
- If wfull rises in the same cycle as a pending beat, the beat is not accepted and must be retried the next cycle.

## Configuration
- FIFO_ARB_PKT_LOCK_EN defined:
  - release happens only on an accepted beat with req_last[g] = 1;
  - MAX_BURST and the valid-drop release are ignored;
  - beat_cnt is still counted but does not trigger release.
- FIFO_ARB_PKT_LOCK_EN undefined: req_last is unused and release is as described in Operation.

## Structure
- Package fifo_arb_pkg:
  - typedef enum logic [0:0] arb_state_e {ARB_IDLE, ARB_GRANT};
  - localparam function for wrap-increment of the rr index.
- Sub-module rr_pick: combinational, with inputs req vector and start index and outputs found and index. It is instantiated once in fifo_wr_arbiter.

## Test plan
Parameters: NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8.
- Single requester: req 2 streams 0x10..0x15, FIFO never full → grant_id=2 one cycle after valid; wren/wdata 0x10..0x13, then a 1-cycle bubble, then 0x14,0x15; release on valid drop.
- All four valid continuously → grants in order 0,1,2,3,0, each with exactly 4 wren pulses separated by one idle cycle; rr_ptr wraps 3→0.
- wfull forced high for 3 cycles mid-burst after beat 2 → wren=0 and req_ready[g]=0 for those 3 cycles; grant held; beats 3–4 are then written in order with no loss or duplication.
- Reset asserted during beat 2 of a grant to req 1 → all outputs 0 immediately; after release, req 0 (rr_ptr=0) wins first.
- FIFO_ARB_PKT_LOCK_EN: req 3 sends 7 beats with req_last on beat 7, with req 0 also valid → all 7 beats are written before req 0 is granted; a valid gap of 2 cycles mid-packet does not release the grant.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and helpers for the FIFO write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  // Arbiter states: waiting for a request, or serving one granted requester
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Round-robin index increment with explicit wrap, safe for any requester count
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    rr_wrap_inc = ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter_if
//  Description : Producer-side request bus plus FIFO write port of the
//                arbiter. "slave" is the arbiter view, "master" the
//                producers/FIFO view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDW        = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          wren;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [IDW-1:0]                grant_id;
  logic                          busy;

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, wren, wdata, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, wren, wdata, grant_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin search. Returns the first set
//                request bit found searching upward from start, with wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     start,
  output logic               found,
  output logic [IDW-1:0]     idx
);
  // One extra bit so start+offset never overflows before the wrap
  localparam logic [IDW:0] C_NUM = (IDW+1)'(NUM_REQ);

  logic [IDW:0] w_cand;

  // Scan offsets from farthest to nearest so the nearest hit wins
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, start} + (IDW+1)'(k);
      if (w_cand >= C_NUM) w_cand = w_cand - C_NUM;
      if (req[w_cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = w_cand[IDW-1:0];
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one FIFO write port among
//                NUM_REQ producers. Grants are bounded to MAX_BURST beats,
//                or, with FIFO_ARB_PKT_LOCK_EN defined, held until the beat
//                carrying req_last is accepted. The FIFO full flag gates
//                every beat combinationally so no write is ever dropped.
//  Options     : `define FIFO_ARB_PKT_LOCK_EN for packet-locked grants
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]     beat_q, beat_d;
  logic               busy_q;

  logic               w_found;
  logic [IDW-1:0]     w_pick;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_wren;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BCW-1:0]     w_beat_inc;
  logic               w_release;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .start (rr_ptr_q),
    .found (w_found),
    .idx   (w_pick)
  );

  assign w_beat_inc = beat_q + BCW'(1);

`ifdef FIFO_ARB_PKT_LOCK_EN
  // Grant ends only when the packet's final beat is actually written
  assign w_release = w_wren && bus.req_last[grant_q];
`else
  // Grant ends when the burst budget is used up or the owner goes idle
  assign w_release = !bus.req_valid[grant_q] ||
                     (w_wren && (w_beat_inc == BCW'(MAX_BURST)));
  logic unused_last;
  assign unused_last = ^bus.req_last;
`endif

  // State and grant bookkeeping registers; reset aborts any partial burst
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      busy_q   <= (state_d == ARB_GRANT);
    end
  end

  // Next-state: pick a winner when idle, count beats and release when granted
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      ARB_IDLE: begin
        if (w_found) begin
          state_d = ARB_GRANT;
          grant_d = w_pick;
          beat_d  = '0;
        end
      end
      ARB_GRANT: begin
        if (w_wren) beat_d = w_beat_inc;
        if (w_release) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IDW'(rr_wrap_inc(32'(grant_q), NUM_REQ));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: forward the granted requester straight through, gated by wfull
  always_comb begin
    w_ready = '0;
    w_wren  = 1'b0;
    w_wdata = '0;
    if (state_q == ARB_GRANT) begin
      w_ready[grant_q] = !bus.wfull;
      w_wren           = bus.req_valid[grant_q] && !bus.wfull;
      w_wdata          = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.wren      = w_wren;
  assign bus.wdata     = w_wdata;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter. Producers push
//                expected data per requester as they present it; a monitor
//                pops on every FIFO write and checks grant order, burst
//                bounds, full-flag gating and release behaviour.
//  Options     : honours FIFO_ARB_PKT_LOCK_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    vld = '0;
  logic [N*DW-1:0] dat = '0;
  logic [N-1:0]    lst = '0;
  logic            full_r = 1'b0;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  assign bus.req_valid = vld;
  assign bus.req_data  = dat;
  assign bus.req_last  = lst;
  assign bus.wfull     = full_r;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct { int id; int beats; } grant_t;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [N][$];
  int         rate   [N];
  int         wr_cnt [N];
  int         seq    [N];
  int         issued  = 0;
  int         flushed = 0;
  grant_t     glog[$];
  int         exp_ids[$];
  int         exp_bts[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int from);
    for (int k = 0; k < N; k++) if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic push_item(input int i, input logic [7:0] d, input logic last);
    src_q[i].push_back({last, d});
  endtask

  task automatic push_burst(input int i, input int n, input logic last_at_end);
    for (int k = 0; k < n; k++) begin
      push_item(i, {i[1:0], seq[i][5:0]}, last_at_end && (k == n - 1));
      seq[i]++;
    end
  endtask

  // Producers: hold data until accepted, then optionally present the next item
  initial begin : drv
    logic [N-1:0] acc;
    logic [8:0]   it;
    forever begin
      @(negedge clk);
      acc = vld & bus.req_ready;
      @(posedge clk); #1;
      if (!reset_n) begin
        vld = '0;
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) vld[i] = 1'b0;
        if (!vld[i] && src_q[i].size() > 0 && int'($urandom_range(99)) < rate[i]) begin
          it = src_q[i].pop_front();
          dat[i*DW +: DW] = it[7:0];
          lst[i] = it[8];
          vld[i] = 1'b1;
          exp_q[i].push_back(it[7:0]);
          issued++;
        end
      end
    end
  end

  // Monitor: scoreboard on writes plus grant/release sequencing model
  initial begin : mon
    bit           was_grant = 1'b0;
    bit           prev_idle = 1'b0;
    bit           exp_rel   = 1'b0;
    logic [N-1:0] prev_valid = '0;
    int           beats = 0, last_id = N - 1, exp_id = 0, g;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        was_grant = 1'b0; prev_idle = 1'b0; beats = 0; last_id = N - 1;
        continue;
      end
      g = int'(bus.grant_id);
      if (bus.busy) begin
        chk("ready", 32'(bus.req_ready), bus.wfull ? 32'd0 : (32'd1 << g));
        chk("wren_gate", 32'(bus.wren), 32'(bus.req_valid[g] && !bus.wfull));
      end else begin
        chk("idle_outputs", 32'({bus.wren, bus.req_ready, bus.wdata}), 32'd0);
      end
      if (bus.wren) begin
        if (exp_q[g].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: actual req %0d data 0x%0h required no write", g, bus.wdata);
        end else begin
          chk("wdata", 32'(bus.wdata), 32'(exp_q[g].pop_front()));
        end
        wr_cnt[g]++;
      end
      if (was_grant) begin
        chk("release", 32'(bus.busy), 32'(!exp_rel));
        if (bus.busy) chk("grant_hold", 32'(g), 32'(exp_id));
        if (exp_rel) begin
          glog.push_back('{id: exp_id, beats: beats});
          last_id = exp_id;
        end
      end else if (prev_idle) begin
        if (prev_valid != '0) begin
          chk("grant_taken", 32'(bus.busy), 32'd1);
          chk("rr_winner", 32'(g), 32'(pick(prev_valid, (last_id + 1) % N)));
        end else begin
          chk("stay_idle", 32'(bus.busy), 32'd0);
        end
      end
      if (bus.busy) begin
        if (!was_grant || exp_rel) beats = 0;
        if (bus.wren) beats++;
        exp_id = g;
`ifdef FIFO_ARB_PKT_LOCK_EN
        exp_rel = bus.wren && bus.req_last[g];
`else
        exp_rel = !bus.req_valid[g] || (bus.wren && beats == MB);
`endif
        was_grant = 1'b1; prev_idle = 1'b0;
      end else begin
        was_grant = 1'b0; prev_idle = 1'b1; prev_valid = bus.req_valid;
      end
    end
  end

  task automatic wait_drain(input int max_cyc);
    bit done;
    for (int n = 0; ; n++) begin
      @(negedge clk); #1;
      done = (vld == '0) && !bus.busy;
      for (int i = 0; i < N; i++) done &= (src_q[i].size() == 0) && (exp_q[i].size() == 0);
      if (done) break;
      if (n >= max_cyc) begin
        checks++; errors++;
        $display("FAIL drain_timeout: actual not drained after %0d cycles required drained", n);
        break;
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic wait_writes(input int i, input int target, input int max_cyc);
    for (int n = 0; wr_cnt[i] < target; n++) begin
      if (n >= max_cyc) begin
        checks++; errors++;
        $display("FAIL write_timeout: actual %0d writes required %0d", wr_cnt[i], target);
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic check_log();
    chk("log_len", 32'(glog.size()), 32'(exp_ids.size()));
    for (int k = 0; k < exp_ids.size() && k < glog.size(); k++) begin
      chk("log_id", 32'(glog[k].id), 32'(exp_ids[k]));
      chk("log_beats", 32'(glog[k].beats), 32'(exp_bts[k]));
    end
    glog.delete(); exp_ids.delete(); exp_bts.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_wren"},  32'(bus.wren), 32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_gid"},   32'(bus.grant_id), 32'd0);
  endtask

  initial begin : stim
    int base, tot;
    for (int i = 0; i < N; i++) begin rate[i] = 100; wr_cnt[i] = 0; seq[i] = 0; end
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset");
    #1 reset_n = 1'b1;
    @(negedge clk); #1;

`ifdef FIFO_ARB_PKT_LOCK_EN
    // Packet lock: req 3 holds the port through a valid gap until its last beat
    glog.delete();
    push_burst(3, 3, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    push_burst(0, 2, 1'b1);
    wait_writes(3, 3, 100);
    repeat (2) @(negedge clk);
    #1 push_burst(3, 4, 1'b1);
    wait_drain(200);
    exp_ids.push_back(3); exp_bts.push_back(7);
    exp_ids.push_back(0); exp_bts.push_back(2);
    check_log();
`else
    // Contention: all four stream continuously, four-beat bursts in order
    glog.delete();
    for (int i = 0; i < N; i++) push_burst(i, 8, 1'b1);
    wait_drain(500);
    for (int k = 0; k < 8; k++) begin exp_ids.push_back(k % N); exp_bts.push_back(MB); end
    check_log();

    // Single requester 2 streams 0x10..0x15: burst of 4, bubble, then 2
    for (int k = 0; k < 6; k++) push_item(2, 8'h10 + 8'(k), 1'b0);
    wait_drain(200);
    exp_ids.push_back(2); exp_bts.push_back(4);
    exp_ids.push_back(2); exp_bts.push_back(2);
    check_log();

    // FIFO full for 3 cycles after beat 2: grant and order preserved
    base = wr_cnt[1];
    push_burst(1, 4, 1'b1);
    wait_writes(1, base + 2, 100);
    @(posedge clk); #1 full_r = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("full_busy", 32'(bus.busy), 32'd1);
      chk("full_gid",  32'(bus.grant_id), 32'd1);
      chk("full_wren", 32'(bus.wren), 32'd0);
    end
    @(posedge clk); #1 full_r = 1'b0;
    wait_drain(200);
    exp_ids.push_back(1); exp_bts.push_back(4);
    check_log();

    // Reset during beat 2 of a grant to req 1; afterwards req 0 wins first
    base = wr_cnt[1];
    push_burst(1, 4, 1'b1);
    wait_writes(1, base + 2, 100);
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("abort");
    for (int i = 0; i < N; i++) begin
      flushed += exp_q[i].size();
      exp_q[i].delete(); src_q[i].delete();
    end
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b1;
    glog.delete();
    @(negedge clk); #1;
    push_burst(0, 2, 1'b1);
    push_burst(1, 2, 1'b1);
    wait_drain(200);
    exp_ids.push_back(0); exp_bts.push_back(2);
    exp_ids.push_back(1); exp_bts.push_back(2);
    check_log();
`endif

    // Randomised traffic with random FIFO back-pressure
    for (int i = 0; i < N; i++) rate[i] = 30 + int'($urandom_range(70));
    repeat (300) begin
      @(posedge clk); #1;
      full_r = ($urandom_range(99) < 20);
      if ($urandom_range(99) < 40) begin
        base = int'($urandom_range(N - 1));
        push_item(base, {base[1:0], seq[base][5:0]}, $urandom_range(2) == 0);
        seq[base]++;
      end
    end
    @(posedge clk); #1 full_r = 1'b0;
    for (int i = 0; i < N; i++) push_burst(i, 1, 1'b1);
    wait_drain(3000);
    glog.delete();

    tot = 0;
    for (int i = 0; i < N; i++) tot += wr_cnt[i];
    chk("write_total", 32'(tot), 32'(issued - flushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
